// File: rtl/mor1kx_l15_req_scheduler_pkg.sv
// Shared definitions for the L1.5 request scheduler: FSM encoding, owner IDs
// and the bit layout of the packed request/response payloads.
package mor1kx_l15_req_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } sched_state_e;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    localparam int REQ_W_DEF = 119;
    localparam int RSP_W_DEF = 263;

    // Request: {rqtype[4:0], amo_op[3:0], nc, size[2:0], l1rplway[1:0], address[39:0], data[63:0]}
    localparam int REQ_DATA_LSB   = 0;
    localparam int REQ_ADDR_LSB   = 64;
    localparam int REQ_WAY_LSB    = 104;
    localparam int REQ_SIZE_LSB   = 106;
    localparam int REQ_NC_LSB     = 109;
    localparam int REQ_AMO_LSB    = 110;
    localparam int REQ_RQTYPE_LSB = 114;

    // Response: {returntype[3:0], error[1:0], noncacheable, data_3, data_2, data_1, data_0}
    localparam int RSP_DATA0_LSB = 0;
    localparam int RSP_DATA1_LSB = 64;
    localparam int RSP_DATA2_LSB = 128;
    localparam int RSP_DATA3_LSB = 192;
    localparam int RSP_NC_LSB    = 256;
    localparam int RSP_ERR_LSB   = 257;
    localparam int RSP_RTYPE_LSB = 259;

    function automatic logic [39:0] req_addr(input logic [REQ_W_DEF-1:0] p);
        return p[REQ_ADDR_LSB +: 40];
    endfunction

endpackage

// File: rtl/mor1kx_l15_prio_starve_sel.sv
// Grant select between icache and dcache: dcache wins unless the icache has
// already waited through STARVE_LIMIT consecutive dcache grants.
module mor1kx_l15_prio_starve_sel
    import mor1kx_l15_req_scheduler_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_en_i,
    input  logic ic_req_val_i,
    input  logic dc_req_val_i,
    output logic grant_o,
    output logic grant_owner_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       ic_starved;

    always_comb begin
        ic_starved    = ic_req_val_i && (starve_cnt_q == LIMIT);
        grant_o       = grant_en_i && (ic_req_val_i || dc_req_val_i);
        grant_owner_o = (dc_req_val_i && !ic_starved) ? OWN_DC : OWN_IC;
        starve_cnt_d  = starve_cnt_q;
        if (grant_o) begin
            // Only dcache grants that overtake a waiting icache count toward starvation.
            if ((grant_owner_o == OWN_DC) && ic_req_val_i) begin
                starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
            end else begin
                starve_cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mor1kx_l15_req_scheduler.sv
// Arbitrates the single L1.5 port between icache and dcache transducers.
// Optional response watchdog: define MOR1KX_L15_ARB_WATCHDOG_EN.
module mor1kx_l15_req_scheduler
    import mor1kx_l15_req_scheduler_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int WDT_CYCLES   = 1024,
    parameter int REQ_W        = 119,
    parameter int RSP_W        = 263
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ic_req_val,
    input  logic [REQ_W-1:0] ic_req_payload,
    output logic             ic_req_ack,
    output logic             ic_rsp_val,
    input  logic             ic_rsp_ack,
    input  logic             dc_req_val,
    input  logic [REQ_W-1:0] dc_req_payload,
    output logic             dc_req_ack,
    output logic             dc_rsp_val,
    input  logic             dc_rsp_ack,
    output logic [RSP_W-1:0] rsp_payload,
    output logic             l15_req_val,
    output logic [REQ_W-1:0] l15_req_payload,
    input  logic             l15_req_ack,
    input  logic             l15_header_ack,
    input  logic             l15_rsp_val,
    input  logic [RSP_W-1:0] l15_rsp_payload,
    output logic             l15_rsp_ack,
    output logic             owner,
    output logic             busy,
    output logic             wdt_timeout,
    output logic [1:0]       dbg_state_o,
    output logic             dbg_hdr_ack_o
);

    // Handshakes: a request transfers on a cycle where l15_req_val && l15_req_ack;
    // a response transfers on a cycle where l15_rsp_val && l15_rsp_ack.
    // Requester val is only sampled in IDLE; the latched copy is what gets issued.

    sched_state_e     state_q, state_d;
    logic             owner_q, owner_d;
    logic [REQ_W-1:0] payload_q, payload_d;
    logic             hdr_ack_q, hdr_ack_d;

    logic grant_en;
    logic grant;
    logic grant_owner;
    logic issue_val;
    logic req_ack_fwd;
    logic rsp_fwd;
    logic owner_rsp_ack;
    logic rsp_done;
    logic wdt_hit;

    mor1kx_l15_prio_starve_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio_starve_sel (
        .clk           (clk),
        .rst           (rst),
        .grant_en_i    (grant_en),
        .ic_req_val_i  (ic_req_val),
        .dc_req_val_i  (dc_req_val),
        .grant_o       (grant),
        .grant_owner_o (grant_owner)
    );

    assign grant_en      = (state_q == IDLE);
    assign owner_rsp_ack = (owner_q == OWN_DC) ? dc_rsp_ack : ic_rsp_ack;
    assign rsp_done      = l15_rsp_val && owner_rsp_ack;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        payload_d   = payload_q;
        issue_val   = 1'b0;
        req_ack_fwd = 1'b0;
        rsp_fwd     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d   = ISSUE;
                    owner_d   = grant_owner;
                    payload_d = (grant_owner == OWN_DC) ? dc_req_payload : ic_req_payload;
                end
            end
            ISSUE: begin
                issue_val = 1'b1;
                if (l15_req_ack) begin
                    // A response may arrive alongside the accept; treat it as WAIT_RSP would.
                    req_ack_fwd = 1'b1;
                    rsp_fwd     = 1'b1;
                    state_d     = rsp_done ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                rsp_fwd = 1'b1;
                if (rsp_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (wdt_hit) begin
            state_d     = IDLE;
            req_ack_fwd = 1'b0;
            rsp_fwd     = 1'b0;
        end
    end

    always_comb begin
        hdr_ack_d = hdr_ack_q;
        if (grant_en && grant) begin
            hdr_ack_d = 1'b0;
        end else if (l15_header_ack) begin
            hdr_ack_d = 1'b1;
        end
    end

`ifdef MOR1KX_L15_ARB_WATCHDOG_EN
    logic [15:0] wdt_cnt_q, wdt_cnt_d;

    assign wdt_hit = (state_q != IDLE) && (wdt_cnt_q == 16'(WDT_CYCLES));

    always_comb begin
        wdt_cnt_d = wdt_cnt_q + 16'd1;
        if ((state_q == IDLE) || (state_d != state_q)) begin
            wdt_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_q <= 16'd0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
        end
    end
`else
    assign wdt_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IC;
            payload_q <= '0;
            hdr_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            payload_q <= payload_d;
            hdr_ack_q <= hdr_ack_d;
        end
    end

    assign l15_req_val     = issue_val;
    assign l15_req_payload = payload_q;
    assign ic_req_ack      = req_ack_fwd && (owner_q == OWN_IC);
    assign dc_req_ack      = req_ack_fwd && (owner_q == OWN_DC);
    assign ic_rsp_val      = rsp_fwd && l15_rsp_val && (owner_q == OWN_IC);
    assign dc_rsp_val      = rsp_fwd && l15_rsp_val && (owner_q == OWN_DC);
    assign l15_rsp_ack     = rsp_fwd && owner_rsp_ack;
    assign rsp_payload     = l15_rsp_payload;
    assign owner           = owner_q;
    assign busy            = (state_q != IDLE);
    assign wdt_timeout     = wdt_hit;
    assign dbg_state_o     = state_q;
    assign dbg_hdr_ack_o   = hdr_ack_q;

endmodule
